// File: rtl/vx_vec_dispatch_gather.sv
// Collects the per-lane beats of one vector instruction into a single wide request.
// Scalar beats are forwarded unchanged, but only while no gather is in progress.
module vx_vec_dispatch_gather #(
    parameter int LANES       = 4,
    parameter int LANEID_BITS = 3,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 16,
    parameter int WIS_W       = 4,
    parameter int PC_W        = 32,
    parameter int ALU_W       = 4,
    parameter int ARGS_W      = 16,
    parameter int NR_W        = 6,
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int TW         = LANES * NUM_THREADS,
    localparam int LDW        = NUM_THREADS * XLEN,
    localparam int DW         = TW * XLEN
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [UUID_W-1:0]      dispatch_uuid,
    input  logic [WIS_W-1:0]       dispatch_wis,
    input  logic [NUM_THREADS-1:0] dispatch_tmask,
    input  logic [PC_W-1:0]        dispatch_PC,
    input  logic [ALU_W-1:0]       dispatch_op_type,
    input  logic [ARGS_W-1:0]      dispatch_op_args,
    input  logic                   dispatch_wb,
    input  logic [NR_W-1:0]        dispatch_rd,
    input  logic [LDW-1:0]         dispatch_rs1_data,
    input  logic [LDW-1:0]         dispatch_rs2_data,
    input  logic [LDW-1:0]         dispatch_rs3_data,
    input  logic                   dispatch_is_vec,
    input  logic [NR_W-1:0]        dispatch_vd,
    input  logic [LANEID_BITS-1:0] dispatch_vd_lane_id,
    input  logic                   dispatch_vd_is_last,

    output logic                   scalar_valid,
    input  logic                   scalar_ready,
    output logic [UUID_W-1:0]      scalar_uuid,
    output logic [WIS_W-1:0]       scalar_wis,
    output logic [NUM_THREADS-1:0] scalar_tmask,
    output logic [PC_W-1:0]        scalar_PC,
    output logic [ALU_W-1:0]       scalar_op_type,
    output logic [ARGS_W-1:0]      scalar_op_args,
    output logic                   scalar_wb,
    output logic [NR_W-1:0]        scalar_rd,
    output logic [LDW-1:0]         scalar_rs1_data,
    output logic [LDW-1:0]         scalar_rs2_data,
    output logic [LDW-1:0]         scalar_rs3_data,

    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic [UUID_W-1:0]      vec_uuid,
    output logic [WIS_W-1:0]       vec_wis,
    output logic [PC_W-1:0]        vec_PC,
    output logic [ALU_W-1:0]       vec_op_type,
    output logic [ARGS_W-1:0]      vec_op_args,
    output logic                   vec_wb,
    output logic [NR_W-1:0]        vec_vd,
    output logic [TW-1:0]          vec_tmask,
    output logic [DW-1:0]          vec_rs1_data,
    output logic [DW-1:0]          vec_rs2_data,
    output logic [DW-1:0]          vec_rs3_data,
    output logic [LANES-1:0]       vec_lane_mask,
    output logic                   err_sticky
);

    typedef enum logic [1:0] {IDLE, GATHER, OUT} state_e;

    state_e             state_q, state_d;
    logic [UUID_W-1:0]  uuid_q;
    logic [WIS_W-1:0]   wis_q;
    logic [PC_W-1:0]    pc_q;
    logic [ALU_W-1:0]   opType_q;
    logic [ARGS_W-1:0]  opArgs_q;
    logic               wb_q;
    logic [NR_W-1:0]    vd_q;
    logic [TW-1:0]      tmask_q;
    logic [DW-1:0]      rs1_q, rs2_q, rs3_q;
    logic [LANES-1:0]   laneMask_q;
    logic               err_q;

    logic               vecAccept;
    logic               laneOk;
    logic [LANE_W-1:0]  laneIdx;
    logic               errBeat;

    assign vecAccept = dispatch_valid & dispatch_is_vec & dispatch_ready;
    assign laneOk    = {1'b0, dispatch_vd_lane_id} < (LANEID_BITS+1)'(LANES);
    assign laneIdx   = dispatch_vd_lane_id[LANE_W-1:0];
    assign errBeat   = !laneOk ||
                       ((state_q == GATHER) && (laneMask_q[laneIdx] || (dispatch_vd != vd_q)));

    // Only one consumer may see a beat: scalar beats go out while idle, vector beats
    // are taken while idle or while gathering for the same warp slot.
    always_comb begin
        dispatch_ready = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                IDLE:    dispatch_ready = dispatch_is_vec ? 1'b1 : scalar_ready;
                GATHER:  dispatch_ready = dispatch_is_vec && (dispatch_wis == wis_q);
                default: dispatch_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vecAccept) state_d = dispatch_vd_is_last ? OUT : GATHER;
            GATHER:  if (vecAccept && dispatch_vd_is_last) state_d = OUT;
            OUT:     if (vec_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first beat wipes every lane slot before writing its own, so lanes left
    // unwritten by this instruction always read back as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uuid_q     <= '0;
            wis_q      <= '0;
            pc_q       <= '0;
            opType_q   <= '0;
            opArgs_q   <= '0;
            wb_q       <= 1'b0;
            vd_q       <= '0;
            tmask_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs3_q      <= '0;
            laneMask_q <= '0;
            err_q      <= 1'b0;
        end else if (vecAccept) begin
            if (state_q == IDLE) begin
                uuid_q     <= dispatch_uuid;
                wis_q      <= dispatch_wis;
                pc_q       <= dispatch_PC;
                opType_q   <= dispatch_op_type;
                opArgs_q   <= dispatch_op_args;
                wb_q       <= dispatch_wb;
                vd_q       <= dispatch_vd;
                tmask_q    <= '0;
                rs1_q      <= '0;
                rs2_q      <= '0;
                rs3_q      <= '0;
                laneMask_q <= '0;
            end
            if (laneOk) begin
                tmask_q[laneIdx*NUM_THREADS +: NUM_THREADS] <= dispatch_tmask;
                rs1_q[laneIdx*LDW +: LDW]                   <= dispatch_rs1_data;
                rs2_q[laneIdx*LDW +: LDW]                   <= dispatch_rs2_data;
                rs3_q[laneIdx*LDW +: LDW]                   <= dispatch_rs3_data;
                laneMask_q[laneIdx]                         <= 1'b1;
            end
            if (errBeat) begin
                err_q <= 1'b1;
            end
        end
    end

    assign scalar_valid    = reset_n & dispatch_valid & ~dispatch_is_vec & (state_q == IDLE);
    assign scalar_uuid     = dispatch_uuid;
    assign scalar_wis      = dispatch_wis;
    assign scalar_tmask    = dispatch_tmask;
    assign scalar_PC       = dispatch_PC;
    assign scalar_op_type  = dispatch_op_type;
    assign scalar_op_args  = dispatch_op_args;
    assign scalar_wb       = dispatch_wb;
    assign scalar_rd       = dispatch_rd;
    assign scalar_rs1_data = dispatch_rs1_data;
    assign scalar_rs2_data = dispatch_rs2_data;
    assign scalar_rs3_data = dispatch_rs3_data;

    assign vec_valid     = (state_q == OUT);
    assign vec_uuid      = uuid_q;
    assign vec_wis       = wis_q;
    assign vec_PC        = pc_q;
    assign vec_op_type   = opType_q;
    assign vec_op_args   = opArgs_q;
    assign vec_wb        = wb_q;
    assign vec_vd        = vd_q;
    assign vec_tmask     = tmask_q;
    assign vec_rs1_data  = rs1_q;
    assign vec_rs2_data  = rs2_q;
    assign vec_rs3_data  = rs3_q;
    assign vec_lane_mask = laneMask_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_vx_vec_dispatch_gather.sv
// Scoreboard bench for vx_vec_dispatch_gather: directed protocol cases followed by
// random scalar/vector traffic checked against a lane-array reference model.
module tb_vx_vec_dispatch_gather;
    localparam int LANES = 4, LIDB = 3, NT = 4, XLEN = 32;
    localparam int UW = 16, WW = 4, PW = 32, AW = 4, OW = 16, RW = 6;
    localparam int TW = LANES*NT, LDW = NT*XLEN, DW = TW*XLEN;
    localparam int HW = UW+WW+PW+AW+OW+1+RW;

    typedef struct {
        bit              isVec;
        logic [UW-1:0]   uuid;
        logic [WW-1:0]   wis;
        logic [NT-1:0]   tmask;
        logic [PW-1:0]   pc;
        logic [AW-1:0]   opType;
        logic [OW-1:0]   opArgs;
        logic            wb;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   vd;
        logic [LIDB-1:0] lane;
        logic            last;
        logic [LDW-1:0]  rs1, rs2, rs3;
    } beat_t;

    typedef struct {
        logic [HW-1:0]    hdr;
        logic [TW-1:0]    tmask;
        logic [LANES-1:0] mask;
        logic [DW-1:0]    rs1, rs2, rs3;
    } vecExp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic dispatch_valid, dispatch_ready;
    logic [UW-1:0] dispatch_uuid;  logic [WW-1:0] dispatch_wis;  logic [NT-1:0] dispatch_tmask;
    logic [PW-1:0] dispatch_PC;    logic [AW-1:0] dispatch_op_type; logic [OW-1:0] dispatch_op_args;
    logic dispatch_wb;             logic [RW-1:0] dispatch_rd;
    logic [LDW-1:0] dispatch_rs1_data, dispatch_rs2_data, dispatch_rs3_data;
    logic dispatch_is_vec;         logic [RW-1:0] dispatch_vd;
    logic [LIDB-1:0] dispatch_vd_lane_id; logic dispatch_vd_is_last;
    logic scalar_valid, scalar_ready;
    logic [UW-1:0] scalar_uuid;    logic [WW-1:0] scalar_wis;    logic [NT-1:0] scalar_tmask;
    logic [PW-1:0] scalar_PC;      logic [AW-1:0] scalar_op_type; logic [OW-1:0] scalar_op_args;
    logic scalar_wb;               logic [RW-1:0] scalar_rd;
    logic [LDW-1:0] scalar_rs1_data, scalar_rs2_data, scalar_rs3_data;
    logic vec_valid, vec_ready;
    logic [UW-1:0] vec_uuid;       logic [WW-1:0] vec_wis;       logic [PW-1:0] vec_PC;
    logic [AW-1:0] vec_op_type;    logic [OW-1:0] vec_op_args;   logic vec_wb;
    logic [RW-1:0] vec_vd;         logic [TW-1:0] vec_tmask;
    logic [DW-1:0] vec_rs1_data, vec_rs2_data, vec_rs3_data;
    logic [LANES-1:0] vec_lane_mask;
    logic err_sticky;

    int total = 0;
    int bad = 0;
    bit randReady = 1'b0;
    bit errModel = 1'b0;
    logic [511:0] scalarQ[$];
    vecExp_t vecQ[$];
    beat_t beatQ[$];

    vx_vec_dispatch_gather #(
        .LANES(LANES), .LANEID_BITS(LIDB), .NUM_THREADS(NT), .XLEN(XLEN), .UUID_W(UW),
        .WIS_W(WW), .PC_W(PW), .ALU_W(AW), .ARGS_W(OW), .NR_W(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_uuid(dispatch_uuid), .dispatch_wis(dispatch_wis), .dispatch_tmask(dispatch_tmask),
        .dispatch_PC(dispatch_PC), .dispatch_op_type(dispatch_op_type), .dispatch_op_args(dispatch_op_args),
        .dispatch_wb(dispatch_wb), .dispatch_rd(dispatch_rd),
        .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
        .dispatch_rs3_data(dispatch_rs3_data), .dispatch_is_vec(dispatch_is_vec), .dispatch_vd(dispatch_vd),
        .dispatch_vd_lane_id(dispatch_vd_lane_id), .dispatch_vd_is_last(dispatch_vd_is_last),
        .scalar_valid(scalar_valid), .scalar_ready(scalar_ready),
        .scalar_uuid(scalar_uuid), .scalar_wis(scalar_wis), .scalar_tmask(scalar_tmask),
        .scalar_PC(scalar_PC), .scalar_op_type(scalar_op_type), .scalar_op_args(scalar_op_args),
        .scalar_wb(scalar_wb), .scalar_rd(scalar_rd), .scalar_rs1_data(scalar_rs1_data),
        .scalar_rs2_data(scalar_rs2_data), .scalar_rs3_data(scalar_rs3_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_uuid(vec_uuid), .vec_wis(vec_wis),
        .vec_PC(vec_PC), .vec_op_type(vec_op_type), .vec_op_args(vec_op_args), .vec_wb(vec_wb),
        .vec_vd(vec_vd), .vec_tmask(vec_tmask), .vec_rs1_data(vec_rs1_data),
        .vec_rs2_data(vec_rs2_data), .vec_rs3_data(vec_rs3_data),
        .vec_lane_mask(vec_lane_mask), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] packScalar(input beat_t b);
        return 512'({b.uuid, b.wis, b.tmask, b.pc, b.opType, b.opArgs, b.wb, b.rd, b.rs1, b.rs2, b.rs3});
    endfunction

    function automatic beat_t randBeat(input bit isVec);
        beat_t b;
        b.isVec = isVec;
        b.uuid = UW'($urandom);  b.wis = WW'($urandom);  b.tmask = NT'($urandom);
        b.pc = $urandom;         b.opType = AW'($urandom); b.opArgs = OW'($urandom);
        b.wb = 1'($urandom);     b.rd = RW'($urandom);  b.vd = RW'($urandom);
        b.lane = '0;             b.last = 1'b0;
        for (int t = 0; t < NT; t++) begin
            b.rs1[t*XLEN +: XLEN] = $urandom;
            b.rs2[t*XLEN +: XLEN] = $urandom;
            b.rs3[t*XLEN +: XLEN] = $urandom;
        end
        return b;
    endfunction

    // Reference: replay the beats into per-lane arrays, last write wins, then flatten.
    function automatic vecExp_t modelGather(input beat_t q[$], output bit err);
        vecExp_t e;
        logic [NT-1:0]  tm [LANES];
        logic [LDW-1:0] r1 [LANES];
        logic [LDW-1:0] r2 [LANES];
        logic [LDW-1:0] r3 [LANES];
        bit written [LANES];
        err = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            tm[l] = '0; r1[l] = '0; r2[l] = '0; r3[l] = '0; written[l] = 1'b0;
        end
        e.hdr = {q[0].uuid, q[0].wis, q[0].pc, q[0].opType, q[0].opArgs, q[0].wb, q[0].vd};
        foreach (q[i]) begin
            if (int'(q[i].lane) >= LANES) begin
                err = 1'b1;
            end else begin
                if (written[q[i].lane]) err = 1'b1;
                written[q[i].lane] = 1'b1;
                tm[q[i].lane] = q[i].tmask;
                r1[q[i].lane] = q[i].rs1;
                r2[q[i].lane] = q[i].rs2;
                r3[q[i].lane] = q[i].rs3;
            end
            if (q[i].vd != q[0].vd) err = 1'b1;
        end
        for (int l = 0; l < LANES; l++) begin
            e.tmask[l*NT +: NT] = tm[l];
            e.rs1[l*LDW +: LDW] = r1[l];
            e.rs2[l*LDW +: LDW] = r2[l];
            e.rs3[l*LDW +: LDW] = r3[l];
            e.mask[l] = written[l];
        end
        return e;
    endfunction

    task automatic modelVec();
        bit e;
        vecQ.push_back(modelGather(beatQ, e));
        errModel = errModel | e;
    endtask

    task automatic driveBus(input beat_t b, input bit v);
        dispatch_valid = v;           dispatch_is_vec = b.isVec;   dispatch_uuid = b.uuid;
        dispatch_wis = b.wis;         dispatch_tmask = b.tmask;    dispatch_PC = b.pc;
        dispatch_op_type = b.opType;  dispatch_op_args = b.opArgs; dispatch_wb = b.wb;
        dispatch_rd = b.rd;           dispatch_vd = b.vd;          dispatch_vd_lane_id = b.lane;
        dispatch_vd_is_last = b.last; dispatch_rs1_data = b.rs1;
        dispatch_rs2_data = b.rs2;    dispatch_rs3_data = b.rs3;
    endtask

    // Present one beat until it is accepted, with a bounded wait.
    task automatic applyStimulus(input beat_t b);
        bit ok = 1'b0;
        driveBus(b, 1'b1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dispatch_ready) begin
                ok = 1'b1;
                nextCyc();
                break;
            end
            nextCyc();
        end
        if (!ok) checkOutput("beatTimeout", 512'(0), 512'(1));
        dispatch_valid = 1'b0;
    endtask

    task automatic sendAll();
        foreach (beatQ[i]) applyStimulus(beatQ[i]);
    endtask

    task automatic buildVec(input int lanes[$], input logic [WW-1:0] wis, input logic [RW-1:0] vd);
        beat_t b;
        beatQ.delete();
        foreach (lanes[i]) begin
            b = randBeat(1'b1);
            b.wis = wis;
            b.vd = vd;
            b.lane = LIDB'(lanes[i]);
            b.last = (i == lanes.size()-1);
            beatQ.push_back(b);
        end
    endtask

    // Monitor: pops the scoreboard whenever a handshake is about to complete.
    always @(negedge clk) begin
        if (reset_n) begin
            if (scalar_valid && scalar_ready) begin
                if (scalarQ.size() == 0) checkOutput("scalarUnexpected", 512'(1), 512'(0));
                else checkOutput("scalarData", 512'({scalar_uuid, scalar_wis, scalar_tmask, scalar_PC,
                    scalar_op_type, scalar_op_args, scalar_wb, scalar_rd, scalar_rs1_data,
                    scalar_rs2_data, scalar_rs3_data}), scalarQ.pop_front());
            end
            if (vec_valid && vec_ready) begin
                if (vecQ.size() == 0) begin
                    checkOutput("vecUnexpected", 512'(1), 512'(0));
                end else begin
                    vecExp_t e;
                    e = vecQ.pop_front();
                    checkOutput("vecHdr", 512'({vec_uuid, vec_wis, vec_PC, vec_op_type, vec_op_args,
                        vec_wb, vec_vd}), 512'(e.hdr));
                    checkOutput("vecTmask", 512'(vec_tmask), 512'(e.tmask));
                    checkOutput("vecLaneMask", 512'(vec_lane_mask), 512'(e.mask));
                    checkOutput("vecRs1", vec_rs1_data, e.rs1);
                    checkOutput("vecRs2", vec_rs2_data, e.rs2);
                    checkOutput("vecRs3", vec_rs3_data, e.rs3);
                end
            end
        end
    end

    // Random backpressure, applied off the driver's phase so directed code can take over.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (randReady) begin
                vec_ready = ($urandom % 3) != 0;
                scalar_ready = ($urandom % 3) != 0;
            end
        end
    end

    initial begin
        beat_t b, sb;
        logic [DW-1:0] expRs1;
        int lanes[$];
        reset_n = 1'b1;
        vec_ready = 1'b0;
        scalar_ready = 1'b0;
        b = randBeat(1'b0);
        driveBus(b, 1'b0);
        #1 reset_n = 1'b0;

        // Reset state, with a scalar beat offered during reset.
        driveBus(b, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstVecValid", 512'(vec_valid), 512'(0));
        checkOutput("rstErr", 512'(err_sticky), 512'(0));
        checkOutput("rstScalarValid", 512'(scalar_valid), 512'(0));
        checkOutput("rstLaneMask", 512'(vec_lane_mask), 512'(0));
        nextCyc();
        reset_n = 1'b1;
        dispatch_valid = 1'b0;
        nextCyc();

        // Scalar pass-through, first blocked then accepted.
        b = randBeat(1'b0);
        b.uuid = 16'd5;
        driveBus(b, 1'b1);
        @(negedge clk);
        checkOutput("scalarStallReady", 512'(dispatch_ready), 512'(0));
        checkOutput("scalarValidNoReady", 512'(scalar_valid), 512'(1));
        checkOutput("scalarVecIdle", 512'(vec_valid), 512'(0));
        nextCyc();
        scalar_ready = 1'b1;
        scalarQ.push_back(packScalar(b));
        applyStimulus(b);

        // Four-beat gather held under backpressure, with a scalar beat waiting behind it.
        lanes = '{0, 1, 2, 3};
        buildVec(lanes, 4'd3, 6'd7);
        expRs1 = '0;
        foreach (beatQ[i]) begin
            for (int t = 0; t < NT; t++) beatQ[i].rs1[t*XLEN +: XLEN] = 32'(16*i);
            for (int t = 0; t < NT; t++) expRs1[(i*NT+t)*XLEN +: XLEN] = 32'(16*i);
        end
        modelVec();
        sendAll();
        b = randBeat(1'b1);
        b.wis = 4'd3;
        driveBus(b, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("outValid%0d", k), 512'(vec_valid), 512'(1));
            checkOutput($sformatf("outHoldRs1_%0d", k), vec_rs1_data, expRs1);
            if (k == 0) begin
                checkOutput("outVecStall", 512'(dispatch_ready), 512'(0));
                checkOutput("outLaneMask", 512'(vec_lane_mask), 512'(4'b1111));
            end
            nextCyc();
        end
        sb = randBeat(1'b0);
        scalarQ.push_back(packScalar(sb));
        driveBus(sb, 1'b1);
        @(negedge clk);
        checkOutput("outScalarStall", 512'(dispatch_ready), 512'(0));
        nextCyc();
        vec_ready = 1'b1;
        @(negedge clk);
        checkOutput("handshakeScalarStall", 512'(dispatch_ready), 512'(0));
        nextCyc();
        @(negedge clk);
        checkOutput("scalarResume", 512'(dispatch_ready), 512'(1));
        nextCyc();
        dispatch_valid = 1'b0;

        // Single beat on lane 2.
        lanes = '{2};
        buildVec(lanes, 4'd1, 6'd2);
        modelVec();
        sendAll();
        @(negedge clk);
        checkOutput("singleValid", 512'(vec_valid), 512'(1));
        checkOutput("singleMask", 512'(vec_lane_mask), 512'(4'b0100));
        checkOutput("singleOtherTmask", 512'(vec_tmask & ~(TW'({NT{1'b1}}) << (2*NT))), 512'(0));
        checkOutput("noErrYet", 512'(err_sticky), 512'(0));
        nextCyc();

        // Out-of-range lane plus duplicate lane 1; the second write must win.
        lanes = '{0, 5, 1, 1};
        buildVec(lanes, 4'd2, 6'd9);
        modelVec();
        sendAll();
        @(negedge clk);
        checkOutput("errSticky", 512'(err_sticky), 512'(1));
        checkOutput("dupSecondWins", 512'(vec_rs1_data[LDW +: LDW]), 512'(beatQ[3].rs1));
        nextCyc();

        // A beat from another warp slot is stalled mid-gather.
        lanes = '{0, 1};
        buildVec(lanes, 4'd1, 6'd4);
        modelVec();
        applyStimulus(beatQ[0]);
        b = beatQ[1];
        b.wis = 4'd2;
        driveBus(b, 1'b1);
        @(negedge clk);
        checkOutput("wisStall", 512'(dispatch_ready), 512'(0));
        nextCyc();
        applyStimulus(beatQ[1]);
        nextCyc();

        // Reset after two of four beats discards the partial gather.
        vec_ready = 1'b0;
        lanes = '{0, 2, 1, 3};
        buildVec(lanes, 4'd6, 6'd1);
        applyStimulus(beatQ[0]);
        applyStimulus(beatQ[1]);
        reset_n = 1'b0;
        errModel = 1'b0;
        @(negedge clk);
        checkOutput("midRstVecValid", 512'(vec_valid), 512'(0));
        checkOutput("midRstErr", 512'(err_sticky), 512'(0));
        nextCyc();
        reset_n = 1'b1;
        b = randBeat(1'b1);
        driveBus(b, 1'b0);
        @(negedge clk);
        checkOutput("postRstIdleReady", 512'(dispatch_ready), 512'(1));
        nextCyc();
        vec_ready = 1'b1;
        lanes = '{1, 3};
        buildVec(lanes, 4'd6, 6'd1);
        modelVec();
        sendAll();
        @(negedge clk);
        checkOutput("postRstMask", 512'(vec_lane_mask), 512'(4'b1010));
        nextCyc();

        // Random mixed traffic.
        randReady = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom % 3 == 0) begin
                b = randBeat(1'b0);
                scalarQ.push_back(packScalar(b));
                applyStimulus(b);
            end else begin
                int nb;
                logic [WW-1:0] w;
                logic [RW-1:0] v;
                nb = 1 + $urandom % 5;
                w = WW'($urandom);
                v = RW'($urandom);
                lanes.delete();
                for (int i = 0; i < nb; i++)
                    lanes.push_back(($urandom % 10 == 0) ? 4 + $urandom % 4 : $urandom % LANES);
                buildVec(lanes, w, v);
                if ($urandom % 8 == 0) beatQ[nb-1].vd = v + 6'd1;
                modelVec();
                foreach (beatQ[i]) begin
                    applyStimulus(beatQ[i]);
                    if ($urandom % 4 == 0) nextCyc();
                end
            end
        end

        for (int i = 0; i < 1000 && (scalarQ.size() != 0 || vecQ.size() != 0); i++) nextCyc();
        randReady = 1'b0;
        checkOutput("scalarQEmpty", 512'(scalarQ.size()), 512'(0));
        checkOutput("vecQEmpty", 512'(vecQ.size()), 512'(0));
        checkOutput("finalErr", 512'(err_sticky), 512'(errModel));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vx_vec_dispatch_gather.md
Name: vx_vec_dispatch_gather

Overview:
- Slave-side consumer of the dispatch interface.
- Vector instructions arrive as per-lane beats tagged is_vec / vd / vd_lane_id / vd_is_last. This block gathers the beats of one vector instruction into a single wide request for the vector execute unit.
- Non-vector packets bypass to a scalar dispatch master unchanged.
- Sits between the dispatch unit and the ALU/vector execute pair.

Parameters:
- LANES, 4: lanes gathered per vector instruction; must be ≤ 2**`LANEID_BITS.
- LANE_W, `CLOG2(LANES): lane index width used internally.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- dispatch_if  slave  VX_dispatch_if  incoming beats.
- scalar_if  master  VX_dispatch_if  non-vector pass-through.
- vec_valid  out  1  gathered request valid.
- vec_ready  in  1  vector unit accepts.
- vec_uuid  out  `UUID_WIDTH  uuid of first beat.
- vec_wis  out  ISSUE_WIS_W  warp slot.
- vec_PC  out  `PC_BITS  PC of first beat.
- vec_op_type  out  `INST_ALU_BITS  op type.
- vec_op_args  out  op_args_t  op args.
- vec_wb  out  1  writeback enable.
- vec_vd  out  `NR_BITS  destination vector register.
- vec_tmask  out  LANES*`NUM_THREADS  per-lane thread masks; lane i occupies bits [i*NT +: NT].
- vec_rs1_data / vec_rs2_data / vec_rs3_data  out  LANES*`NUM_THREADS*`XLEN  per-lane operands.
- vec_lane_mask  out  LANES  lanes written in this gather.
- err_sticky  out  1  protocol error seen since reset.

Behaviour:
- FSM states: IDLE, GATHER, OUT. Reset (reset_n=0, async) → IDLE. All of the following clear to 0: registers, vec_valid, lane_mask, err_sticky, scalar_if.valid.
- Scalar path is combinational and active only in IDLE:
  - scalar_if.valid = dispatch_if.valid & ~is_vec & (state==IDLE).
  - scalar_if.data = dispatch_if.data.
  - dispatch_if.ready = scalar_if.ready for a scalar beat in IDLE.
  - In GATHER or OUT, scalar beats are stalled (ready=0).
- Vector beat handshake: a beat is accepted when dispatch_if.valid & ready.
  - IDLE: ready=1.
  - GATHER: ready=1 only if beat wis == captured wis; otherwise ready=0 (stall).
  - OUT: ready=0.
- First vector beat in IDLE:
  - Capture uuid, wis, PC, op_type, op_args, wb, vd.
  - Clear all lane slots: tmask and data to 0, lane_mask to 0.
  - Write the lane slot.
  - Next state is OUT if vd_is_last, else GATHER.
- Lane write:
  - Slot vd_lane_id receives tmask and rs1/2/3_data, and its lane_mask bit is set.
  - If vd_lane_id ≥ LANES: no write, err_sticky ← 1, beat still consumed.
  - If the lane_mask bit is already set: overwrite, err_sticky ← 1.
- GATHER: each accepted beat writes its lane. On a beat with vd_is_last, go to OUT. Header fields are not re-captured; a vd mismatch sets err_sticky.
- OUT: vec_valid=1, outputs driven from registers and held stable until vec_valid & vec_ready. Next cycle → IDLE, vec_valid=0.
- Latency: last beat accepted at cycle N → vec_valid high at N+1. Earliest next accepted beat at N+2 if vec_ready is high at N+1.
- Unwritten lanes present tmask=0 and data=0.
- vec_* outputs are don't-care while vec_valid=0. Tie them to registers; hold the last values.
- Reset mid-GATHER or mid-OUT discards the partial request with no output.
- err_sticky is cleared only by reset.

Test Plan:
- Scalar only: is_vec=0, uuid=5, scalar_if.ready=1 → scalar_if.valid same cycle with uuid=5, vec_valid stays 0. With scalar_if.ready=0 → dispatch_if.ready=0.
- Four-beat gather, LANES=4: lanes 0..3, rs1=lane*16, is_last on lane 3, vec_ready=1 → vec_valid at the cycle after beat 3; vec_lane_mask=4'b1111; rs1 slot i=16*i; ready=0 during OUT.
- Single beat: lane 2, is_last=1 → OUT next cycle; lane_mask=4'b0100; lanes 0,1,3 tmask=0.
- Backpressure: vec_ready=0 for 5 cycles in OUT → vec_valid and data stable. A concurrent scalar beat stalls until the cycle after the handshake.
- Errors: lane id 5 with LANES=4, or a duplicate lane 1 → err_sticky=1, duplicate lane holds its second value. A beat with a different wis during GATHER sees ready=0.
- Reset: reset_n low after 2 of 4 beats → vec_valid=0, state IDLE. A new full gather then completes with only its own lanes in lane_mask.
